// File: rtl/fft8_ctrl_pkg.sv
// Shared types and helpers for the 8-point radix-2 DIT FFT stage sequencer.
// Contents: FSM state enum, butterfly address record, write-back/output tag,
// bit-reverse helper and the per-stage butterfly address generator.
package fft8_ctrl_pkg;

    localparam int unsigned N_POINTS = 8;
    localparam int unsigned LOG2N    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_OUTPUT
    } state_t;

    // Addresses for one butterfly: top, bottom and twiddle index k of W8^k
    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
    } bf_addr_t;

    // Tag carried through the control delay lines
    typedef struct packed {
        logic       valid;
        logic [2:0] addr;
    } ctrl_tag_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    // In-place DIT addressing: groups of 2*span, butterfly pos inside group
    function automatic bf_addr_t bf_addr(input logic [1:0] stage, input logic [1:0] bfly);
        logic [2:0] span;
        logic [2:0] pos;
        logic [2:0] grp;
        bf_addr_t   r;
        span = 3'd1 << stage;
        pos  = {1'b0, bfly} & (span - 3'd1);
        grp  = {1'b0, bfly} >> stage;
        r.a  = (grp << (stage + 2'd1)) | pos;
        r.b  = r.a + span;
        r.tw = 2'(pos << (2'd2 - stage));
        return r;
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register for control tags, cleared asynchronously.
// Ports: clk, rst_n (async active-low clear), din (WIDTH), dout (din delayed
// by exactly DEPTH clock edges).
module ctrl_delay_line #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // Shift one slot per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft8_stage_sequencer.sv
// Control sequencer for an 8-point radix-2 DIT FFT sharing one butterfly.
// Ports:
//   CLK, RST (async active-low), Start            - control
//   IN_Valid / IN_Ready, MEM_Wr_En / MEM_Wr_Addr  - bit-reversed input load
//   MEM_Rd_En, MEM_Rd_Addr_A/B, TW_Idx, OP_Sel,
//   Stage                                         - butterfly issue
//   WB_En, WB_Addr                                - delayed datapath write-back
//   OUT_Ready / OUT_Valid, OUT_Idx                - natural-order readout
//   Busy, Done                                    - status
module fft8_stage_sequencer
    import fft8_ctrl_pkg::*;
#(
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned MUL_LATENCY    = 2,
    parameter int unsigned ADDSUB_LATENCY = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       IN_Valid,
    output logic       IN_Ready,
    output logic       MEM_Wr_En,
    output logic [2:0] MEM_Wr_Addr,
    output logic       MEM_Rd_En,
    output logic [2:0] MEM_Rd_Addr_A,
    output logic [2:0] MEM_Rd_Addr_B,
    output logic [1:0] TW_Idx,
    output logic       OP_Sel,
    output logic [1:0] Stage,
    output logic       WB_En,
    output logic [2:0] WB_Addr,
    input  logic       OUT_Ready,
    output logic       OUT_Valid,
    output logic [2:0] OUT_Idx,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned PIPE_LAT   = RD_LATENCY + MUL_LATENCY + ADDSUB_LATENCY;
    localparam logic [2:0]  CNT_LAST   = 3'(N_POINTS - 1);
    localparam logic [2:0]  DRAIN_LAST = 3'(PIPE_LAT - 1);
    localparam logic [1:0]  STAGE_LAST = 2'(LOG2N - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;       // load n / issue c / drain d / output k
    logic [1:0] stage_q, stage_d;
    logic       out_all_q, out_all_d;
    logic       done_q, done_d;

    ctrl_tag_t  wb_in, wb_out;
    ctrl_tag_t  ov_in, ov_out;
    bf_addr_t   bf;
    logic       issue_out;
    logic       last_out;

    assign bf        = bf_addr(stage_q, cnt_q[2:1]);
    assign issue_out = (state_q == ST_OUTPUT) && OUT_Ready && !out_all_q;
    assign last_out  = (state_q == ST_OUTPUT) && ov_out.valid && (ov_out.addr == CNT_LAST);

    // State and counter registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            stage_q   <= '0;
            out_all_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            out_all_q <= out_all_d;
            done_q    <= done_d;
        end
    end

    // Next-state, counters and issue-side outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stage_d       = stage_q;
        out_all_d     = out_all_q;
        done_d        = 1'b0;
        IN_Ready      = 1'b0;
        MEM_Wr_En     = 1'b0;
        MEM_Wr_Addr   = '0;
        MEM_Rd_En     = 1'b0;
        MEM_Rd_Addr_A = '0;
        MEM_Rd_Addr_B = '0;
        TW_Idx        = '0;
        OP_Sel        = 1'b0;
        Stage         = '0;
        wb_in         = '0;
        ov_in         = '0;

        case (state_q)
            ST_IDLE: begin
                // done_q high means this is the Done cycle: a Start here is dropped
                if (Start && !done_q) begin
                    state_d   = ST_LOAD;
                    cnt_d     = '0;
                    stage_d   = '0;
                    out_all_d = 1'b0;
                end
            end

            ST_LOAD: begin
                IN_Ready = 1'b1;
                if (IN_Valid) begin
                    MEM_Wr_En   = 1'b1;
                    MEM_Wr_Addr = bitrev3(cnt_q);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_COMPUTE;
                        cnt_d   = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_COMPUTE: begin
                MEM_Rd_En     = 1'b1;
                MEM_Rd_Addr_A = bf.a;
                MEM_Rd_Addr_B = bf.b;
                TW_Idx        = bf.tw;
                OP_Sel        = cnt_q[0];
                Stage         = stage_q;
                wb_in.valid   = 1'b1;
                wb_in.addr    = cnt_q[0] ? bf.b : bf.a;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            ST_DRAIN: begin
                // Wait out the pipeline so the next stage never reads stale data
                Stage = stage_q;
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_OUTPUT;
                    end else begin
                        state_d = ST_COMPUTE;
                        stage_d = stage_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            ST_OUTPUT: begin
                if (issue_out) begin
                    MEM_Rd_En     = 1'b1;
                    MEM_Rd_Addr_A = cnt_q;
                    ov_in.valid   = 1'b1;
                    ov_in.addr    = cnt_q;
                    if (cnt_q == CNT_LAST) begin
                        out_all_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                if (last_out) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    stage_d   = '0;
                    out_all_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-back strobe lands PIPE_LAT cycles after issue
    ctrl_delay_line #(
        .WIDTH($bits(ctrl_tag_t)),
        .DEPTH(PIPE_LAT)
    ) u_wb_dly (
        .clk  (CLK),
        .rst_n(RST),
        .din  (wb_in),
        .dout (wb_out)
    );

    // Output-valid follows the readout issue by the memory read latency
    ctrl_delay_line #(
        .WIDTH($bits(ctrl_tag_t)),
        .DEPTH(RD_LATENCY)
    ) u_ov_dly (
        .clk  (CLK),
        .rst_n(RST),
        .din  (ov_in),
        .dout (ov_out)
    );

    assign WB_En     = wb_out.valid;
    assign WB_Addr   = wb_out.addr;
    assign OUT_Valid = ov_out.valid;
    assign OUT_Idx   = ov_out.addr;
    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;

endmodule

// File: tb/tb_fft8_stage_sequencer.sv
// Directed bench for fft8_stage_sequencer: default instance (PIPE_LAT 4,
// read latency 1) and a retimed instance (PIPE_LAT 3, read latency 2).
module tb_fft8_stage_sequencer;

    logic       clk;
    logic       rst;
    logic       start_i   [2];
    logic       in_valid  [2];
    logic       out_ready [2];
    logic       in_ready  [2];
    logic       wr_en     [2];
    logic [2:0] wr_addr   [2];
    logic       rd_en     [2];
    logic [2:0] rd_a      [2];
    logic [2:0] rd_b      [2];
    logic [1:0] tw        [2];
    logic       op        [2];
    logic [1:0] stg       [2];
    logic       wb_en     [2];
    logic [2:0] wb_addr   [2];
    logic       out_valid [2];
    logic [2:0] out_idx   [2];
    logic       busy      [2];
    logic       done      [2];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit v;
        int addr;
    } load_vec_t;

    load_vec_t lv [10];
    int        ta [3][4];
    int        tb [3][4];
    int        tt [3][4];
    bit        pat [5];

    fft8_stage_sequencer u_dut0 (
        .CLK(clk), .RST(rst), .Start(start_i[0]), .IN_Valid(in_valid[0]),
        .IN_Ready(in_ready[0]), .MEM_Wr_En(wr_en[0]), .MEM_Wr_Addr(wr_addr[0]),
        .MEM_Rd_En(rd_en[0]), .MEM_Rd_Addr_A(rd_a[0]), .MEM_Rd_Addr_B(rd_b[0]),
        .TW_Idx(tw[0]), .OP_Sel(op[0]), .Stage(stg[0]), .WB_En(wb_en[0]),
        .WB_Addr(wb_addr[0]), .OUT_Ready(out_ready[0]), .OUT_Valid(out_valid[0]),
        .OUT_Idx(out_idx[0]), .Busy(busy[0]), .Done(done[0])
    );

    fft8_stage_sequencer #(
        .RD_LATENCY(2), .MUL_LATENCY(0), .ADDSUB_LATENCY(1)
    ) u_dut1 (
        .CLK(clk), .RST(rst), .Start(start_i[1]), .IN_Valid(in_valid[1]),
        .IN_Ready(in_ready[1]), .MEM_Wr_En(wr_en[1]), .MEM_Wr_Addr(wr_addr[1]),
        .MEM_Rd_En(rd_en[1]), .MEM_Rd_Addr_A(rd_a[1]), .MEM_Rd_Addr_B(rd_b[1]),
        .TW_Idx(tw[1]), .OP_Sel(op[1]), .Stage(stg[1]), .WB_En(wb_en[1]),
        .WB_Addr(wb_addr[1]), .OUT_Ready(out_ready[1]), .OUT_Valid(out_valid[1]),
        .OUT_Idx(out_idx[1]), .Busy(busy[1]), .Done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {in_ready, wr_en, wr_addr, rd_en, A, B, tw, op, stage, wb_en, wb_addr, out_valid, out_idx, busy, done}
    function automatic logic [26:0] act_vec(input int d);
        return {in_ready[d], wr_en[d], wr_addr[d], rd_en[d], rd_a[d], rd_b[d], tw[d], op[d],
                stg[d], wb_en[d], wb_addr[d], out_valid[d], out_idx[d], busy[d], done[d]};
    endfunction

    function automatic logic [26:0] ev(input bit ir, input bit we, input int wa, input bit re,
                                       input int a, input int b, input int t, input bit o,
                                       input int s, input bit wbe, input int wba, input bit ov,
                                       input int oi, input bit bz, input bit dn);
        return {ir, we, 3'(wa), re, 3'(a), 3'(b), 2'(t), o, 2'(s), wbe, 3'(wba), ov, 3'(oi), bz, dn};
    endfunction

    task automatic check(input string name, input int d, input int idx,
                         input logic [26:0] act, input logic [26:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d step %0d: got %h expected %h", name, d, idx, act, exp);
        end
    endtask

    function automatic int dest(input int s, input int c);
        return (c % 2 == 1) ? tb[s][c/2] : ta[s][c/2];
    endfunction

    // One full transform on dut d; optionally reset at (ab_s, ab_t) of COMPUTE/DRAIN
    task automatic run_transform(input int d, input int plat, input int rdl,
                                 input int ab_s, input int ab_t);
        bit ev_v [80];
        int ev_i [80];
        int k;
        bit fin;
        for (int i = 0; i < 80; i++) begin
            ev_v[i] = 1'b0;
            ev_i[i] = 0;
        end

        @(posedge clk); #1;
        start_i[d] = 1'b1;
        #1 check("idle_start", d, 0, act_vec(d), 27'd0);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start_i[d]  = 1'b0;
            in_valid[d] = lv[i].v;
            #1 check("load", d, i, act_vec(d),
                     ev(1, lv[i].v, lv[i].v ? lv[i].addr : 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        end

        for (int s = 0; s < 3; s++) begin
            for (int t = 0; t < 8 + plat; t++) begin
                bit iss;
                bit wbe;
                @(posedge clk); #1;
                in_valid[d] = (s == 0 && t == 0);
                start_i[d]  = (s == 1 && t == 2);
                #1;
                iss = (t < 8);
                wbe = (t >= plat);
                check("compute", d, s * 16 + t, act_vec(d),
                      ev(0, 0, 0, iss,
                         iss ? ta[s][t/2] : 0, iss ? tb[s][t/2] : 0, iss ? tt[s][t/2] : 0,
                         iss ? (t % 2 == 1) : 1'b0, s,
                         wbe, wbe ? dest(s, t - plat) : 0, 0, 0, 1, 0));
                if (s == ab_s && t == ab_t) begin
                    #1 rst = 1'b0;
                    #1 check("reset_async", d, 0, act_vec(d), 27'd0);
                    @(posedge clk); #4;
                    rst = 1'b1;
                    for (int i = 0; i < 10; i++) begin
                        @(posedge clk); #1;
                        in_valid[d] = (i % 2 == 0);
                        #1 check("post_reset", d, i, act_vec(d), 27'd0);
                    end
                    in_valid[d] = 1'b0;
                    return;
                end
            end
        end
        in_valid[d] = 1'b0;
        start_i[d]  = 1'b0;

        k   = 0;
        fin = 1'b0;
        for (int j = 0; j < 60; j++) begin
            bit iss;
            @(posedge clk); #1;
            out_ready[d] = pat[j % 5];
            #1;
            iss = pat[j % 5] && (k < 8);
            check("output", d, j, act_vec(d),
                  ev(0, 0, 0, iss, iss ? k : 0, 0, 0, 0, 0, 0, 0, ev_v[j], ev_i[j], 1, 0));
            if (iss) begin
                ev_v[j + rdl] = 1'b1;
                ev_i[j + rdl] = k;
                k++;
            end
            if (ev_v[j] && ev_i[j] == 7) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL output_timeout dut%0d: got %0d issued, required completion", d, k);
        end

        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        start_i[d]   = 1'b1;
        #1 check("done_pulse", d, 0, act_vec(d), ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk); #1;
        start_i[d] = 1'b0;
        #1 check("after_done", d, 0, act_vec(d), 27'd0);
    endtask

    initial begin
        lv[0] = '{1'b1, 0};
        lv[1] = '{1'b1, 4};
        lv[2] = '{1'b0, 0};
        lv[3] = '{1'b1, 2};
        lv[4] = '{1'b1, 6};
        lv[5] = '{1'b1, 1};
        lv[6] = '{1'b0, 0};
        lv[7] = '{1'b1, 5};
        lv[8] = '{1'b1, 3};
        lv[9] = '{1'b1, 7};
        ta  = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
        tb  = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
        tt  = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_i[d]   = 1'b0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end
        #12;
        check("in_reset", 0, 0, act_vec(0), 27'd0);
        check("in_reset", 1, 0, act_vec(1), 27'd0);
        #10 rst = 1'b1;
        #10;
        check("reset_release", 0, 0, act_vec(0), 27'd0);
        check("reset_release", 1, 0, act_vec(1), 27'd0);

        run_transform(0, 4, 1, -1, -1);
        run_transform(0, 4, 1, 1, 3);
        run_transform(0, 4, 1, -1, -1);
        run_transform(1, 3, 2, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
